// File: rtl/cache_traffic_gen.sv
// cache_traffic_gen: write/read-back traffic generator and self-checker for
// the cache request port. Each address gets a write of a tagged pattern,
// then a read-back whose data is compared under the active byte mask.
// Addresses walk sequentially or follow a 16-bit LFSR inside a power-of-two
// window. The run length is either fixed or open-ended until a stop request.

module cache_traffic_gen #(
    parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
    parameter int unsigned ADDR_WORDS = 512,
    parameter int unsigned GAP_CYCLES = 5,
    parameter int unsigned ITERATIONS = 0,
    parameter logic [31:0] DATA_TAG   = 32'h0123_4567,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_mode,
    input  logic [2:0]  i_bytes,
    output logic [63:0] o_cache_addr,
    output logic [63:0] o_cache_wdata,
    output logic [2:0]  o_cache_bytes,
    output logic        o_cache_op,
    output logic        o_cache_req,
    input  logic [63:0] i_cache_rdata,
    input  logic        i_cache_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_pass_cnt,
    output logic [31:0] o_err_cnt,
    output logic [63:0] o_first_err_addr
);

    // Word-index mask for the window; ADDR_WORDS is a power of two.
    localparam logic [63:0] WORD_MASK = 64'(ADDR_WORDS - 1);
    // Last gap-counter value before the request rises (unused when no gap).
    localparam logic [31:0] GAP_LAST  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
    localparam logic [31:0] ITER_LIM  = 32'(ITERATIONS);
    localparam logic        NO_GAP    = (GAP_CYCLES == 0);

    localparam logic        OP_READ   = 1'b0;
    localparam logic        OP_WRITE  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Mask covering the low (b+1) bytes of a 64-bit word.
    function automatic logic [63:0] byte_mask(input logic [2:0] b);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = (3'(i) <= b) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

    // One step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR, shifting left.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Byte address of a word index folded into the window.
    function automatic logic [63:0] win_addr(input logic [63:0] word);
        return ADDR_BASE + ((word & WORD_MASK) << 3);
    endfunction

    // Saturating 32-bit increment.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [2:0]  bytes_q, bytes_d;
    logic        op_q, op_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mode_q, mode_d;
    logic [31:0] pass_cnt_q, pass_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [63:0] first_err_addr_q, first_err_addr_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] pair_cnt_q, pair_cnt_d;
    logic        stop_flag_q, stop_flag_d;

    logic        hs_s;
    logic        in_run_s;
    logic        match_s;
    logic        stop_now_s;
    logic [15:0] lfsr_nxt_s;

    // Handshake, compare and stop qualifiers used by the next-state logic.
    always_comb begin
        hs_s       = req_q & i_cache_ack;
        in_run_s   = (state_q == ST_GAP) || (state_q == ST_REQ);
        match_s    = ((i_cache_rdata ^ wdata_q) & byte_mask(bytes_q)) == 64'd0;
        lfsr_nxt_s = lfsr_step(lfsr_q);
        stop_now_s = stop_flag_q | i_stop |
                     ((ITER_LIM != 32'd0) && ((pair_cnt_q + 32'd1) == ITER_LIM));
    end

    // Next-state and datapath updates for the write/read-back sequencer.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        bytes_d          = bytes_q;
        op_d             = op_q;
        req_d            = req_q;
        busy_d           = busy_q;
        done_d           = done_q;
        mode_d           = mode_q;
        pass_cnt_d       = pass_cnt_q;
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;
        lfsr_d           = lfsr_q;
        gap_cnt_d        = gap_cnt_q;
        pair_cnt_d       = pair_cnt_q;
        // Stop requests only matter while a run is active.
        stop_flag_d      = stop_flag_q | (i_stop & in_run_s);

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    mode_d           = i_mode;
                    bytes_d          = i_bytes;
                    pass_cnt_d       = 32'd0;
                    err_cnt_d        = 32'd0;
                    first_err_addr_d = 64'd0;
                    done_d           = 1'b0;
                    busy_d           = 1'b1;
                    lfsr_d           = LFSR_SEED;
                    pair_cnt_d       = 32'd0;
                    stop_flag_d      = 1'b0;
                    op_d             = OP_WRITE;
                    addr_d           = i_mode ? win_addr({48'd0, LFSR_SEED}) : ADDR_BASE;
                    // With no gap the request rises on the entry edge itself.
                    if (NO_GAP) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        req_d     = 1'b0;
                        gap_cnt_d = 32'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end

            ST_REQ: begin
                if (hs_s) begin
                    if (op_q == OP_WRITE) begin
                        // Read back the word just written.
                        op_d = OP_READ;
                    end else begin
                        if (match_s) begin
                            pass_cnt_d = sat_inc(pass_cnt_q);
                        end else begin
                            err_cnt_d = sat_inc(err_cnt_q);
                            if (err_cnt_q == 32'd0) begin
                                first_err_addr_d = addr_q;
                            end else begin
                                first_err_addr_d = first_err_addr_q;
                            end
                        end
                        pair_cnt_d  = pair_cnt_q + 32'd1;
                        stop_flag_d = 1'b0;
                        op_d        = OP_WRITE;
                        if (mode_q) begin
                            lfsr_d = lfsr_nxt_s;
                            addr_d = win_addr({48'd0, lfsr_nxt_s});
                        end else begin
                            addr_d = win_addr(((addr_q - ADDR_BASE) >> 3) + 64'd1);
                        end
                    end

                    if ((op_q == OP_READ) && stop_now_s) begin
                        state_d = ST_DONE;
                        req_d   = 1'b0;
                    end else if (NO_GAP) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        req_d     = 1'b0;
                        gap_cnt_d = 32'd0;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Write pattern tracks whatever address is presented next.
        wdata_d = {DATA_TAG, addr_d[31:0]};
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            addr_q           <= ADDR_BASE;
            wdata_q          <= {DATA_TAG, ADDR_BASE[31:0]};
            bytes_q          <= 3'd7;
            op_q             <= OP_READ;
            req_q            <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            mode_q           <= 1'b0;
            pass_cnt_q       <= 32'd0;
            err_cnt_q        <= 32'd0;
            first_err_addr_q <= 64'd0;
            lfsr_q           <= LFSR_SEED;
            gap_cnt_q        <= 32'd0;
            pair_cnt_q       <= 32'd0;
            stop_flag_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            bytes_q          <= bytes_d;
            op_q             <= op_d;
            req_q            <= req_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            mode_q           <= mode_d;
            pass_cnt_q       <= pass_cnt_d;
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
            lfsr_q           <= lfsr_d;
            gap_cnt_q        <= gap_cnt_d;
            pair_cnt_q       <= pair_cnt_d;
            stop_flag_q      <= stop_flag_d;
        end
    end

    assign o_cache_addr     = addr_q;
    assign o_cache_wdata    = wdata_q;
    assign o_cache_bytes    = bytes_q;
    assign o_cache_op       = op_q;
    assign o_cache_req      = req_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_pass_cnt       = pass_cnt_q;
    assign o_err_cnt        = err_cnt_q;
    assign o_first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Directed bench for cache_traffic_gen. Four instances with different
// window/gap/run-length parameters are driven by a small acking memory model.
module tb_cache_traffic_gen;

    localparam int ND = 4;
    localparam int unsigned P_WORDS [ND] = '{512, 4, 512, 512};
    localparam int unsigned P_GAP   [ND] = '{5, 0, 1, 2};
    localparam int unsigned P_ITER  [ND] = '{2, 6, 3, 0};

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [31:0] TAG  = 32'h0123_4567;
    localparam logic [63:0] BIT40 = 64'h0000_0100_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [ND];
    logic        start [ND];
    logic        stop  [ND];
    logic        mode  [ND];
    logic [2:0]  bytes [ND];
    logic [63:0] rdata [ND];
    logic        ack   [ND];
    logic [63:0] addr  [ND];
    logic [63:0] wdata [ND];
    logic [2:0]  obytes[ND];
    logic        op    [ND];
    logic        req   [ND];
    logic        busy  [ND];
    logic        done  [ND];
    logic [31:0] pass  [ND];
    logic [31:0] err   [ND];
    logic [63:0] ferr  [ND];

    int n_checks = 0;
    int n_fails  = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        cache_traffic_gen #(
            .ADDR_WORDS (P_WORDS[g]),
            .GAP_CYCLES (P_GAP[g]),
            .ITERATIONS (P_ITER[g])
        ) u_dut (
            .clk              (clk),
            .rst              (rst[g]),
            .i_start          (start[g]),
            .i_stop           (stop[g]),
            .i_mode           (mode[g]),
            .i_bytes          (bytes[g]),
            .o_cache_addr     (addr[g]),
            .o_cache_wdata    (wdata[g]),
            .o_cache_bytes    (obytes[g]),
            .o_cache_op       (op[g]),
            .o_cache_req      (req[g]),
            .i_cache_rdata    (rdata[g]),
            .i_cache_ack      (ack[g]),
            .o_busy           (busy[g]),
            .o_done           (done[g]),
            .o_pass_cnt       (pass[g]),
            .o_err_cnt        (err[g]),
            .o_first_err_addr (ferr[g])
        );
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle; called and returns at a negedge.
    task automatic start_run(input int d, input logic m, input logic [2:0] b);
        mode[d]  = m;
        bytes[d] = b;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    // Wait for one request, check it, ack it one cycle later.
    task automatic serve(input int d, input logic [63:0] exp_addr, input logic exp_op,
                         input logic [63:0] corrupt, input int exp_gap, input bit pulse_stop);
        int t = 0;
        while (req[d] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("req_seen", {63'd0, req[d]}, 64'd1);
        if (exp_gap >= 0) check_val("gap", 64'(t), 64'(exp_gap));
        check_val("addr", addr[d], exp_addr);
        check_val("op", {63'd0, op[d]}, {63'd0, exp_op});
        check_val("wdata", wdata[d], {TAG, exp_addr[31:0]});
        if (pulse_stop) stop[d] = 1'b1;
        @(negedge clk);
        stop[d]  = 1'b0;
        check_val("addr_hold", addr[d], exp_addr);
        ack[d]   = 1'b1;
        rdata[d] = {TAG, exp_addr[31:0]} ^ corrupt;
        @(negedge clk);
        ack[d]   = 1'b0;
        rdata[d] = 64'd0;
    endtask

    task automatic wait_done(input int d, input logic [31:0] exp_pass, input logic [31:0] exp_err);
        int t = 0;
        while (done[d] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val("done", {63'd0, done[d]}, 64'd1);
        check_val("busy_end", {63'd0, busy[d]}, 64'd0);
        check_val("pass_cnt", {32'd0, pass[d]}, {32'd0, exp_pass});
        check_val("err_cnt", {32'd0, err[d]}, {32'd0, exp_err});
    endtask

    logic [63:0] rnd_addr [3];
    int          seen_req;

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; stop[d] = 1'b0; mode[d] = 1'b0;
            bytes[d] = 3'd7; rdata[d] = 64'd0; ack[d] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset values
        check_val("rst_req", {63'd0, req[0]}, 64'd0);
        check_val("rst_op", {63'd0, op[0]}, 64'd0);
        check_val("rst_bytes", {61'd0, obytes[0]}, 64'd7);
        check_val("rst_addr", addr[0], BASE);
        check_val("rst_wdata", wdata[0], 64'h0123_4567_8000_0000);
        check_val("rst_busy", {63'd0, busy[0]}, 64'd0);
        check_val("rst_done", {63'd0, done[0]}, 64'd0);
        check_val("rst_pass", {32'd0, pass[0]}, 64'd0);
        check_val("rst_err", {32'd0, err[0]}, 64'd0);
        check_val("rst_ferr", ferr[0], 64'd0);
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        @(negedge clk);

        // Basic sequential run of two pairs, gap 5
        start_run(0, 1'b0, 3'd7);
        check_val("busy_run", {63'd0, busy[0]}, 64'd1);
        serve(0, BASE,         1'b1, 64'd0, 5, 1'b0);
        serve(0, BASE,         1'b0, 64'd0, 5, 1'b0);
        serve(0, BASE + 64'd8, 1'b1, 64'd0, 5, 1'b0);
        serve(0, BASE + 64'd8, 1'b0, 64'd0, 5, 1'b0);
        wait_done(0, 32'd2, 32'd0);
        check_val("ferr_none", ferr[0], 64'd0);

        // Bit 40 corrupted on the second read
        start_run(0, 1'b0, 3'd7);
        serve(0, BASE,         1'b1, 64'd0, 5, 1'b0);
        serve(0, BASE,         1'b0, 64'd0, 5, 1'b0);
        serve(0, BASE + 64'd8, 1'b1, 64'd0, 5, 1'b0);
        serve(0, BASE + 64'd8, 1'b0, BIT40, 5, 1'b0);
        wait_done(0, 32'd1, 32'd1);
        check_val("ferr_first", ferr[0], BASE + 64'd8);

        // Both reads corrupted: first error address stays at the first one
        start_run(0, 1'b0, 3'd7);
        serve(0, BASE,         1'b1, 64'd0, -1, 1'b0);
        serve(0, BASE,         1'b0, BIT40, -1, 1'b0);
        serve(0, BASE + 64'd8, 1'b1, 64'd0, -1, 1'b0);
        serve(0, BASE + 64'd8, 1'b0, BIT40, -1, 1'b0);
        wait_done(0, 32'd0, 32'd2);
        check_val("ferr_kept", ferr[0], BASE);

        // 4-byte transfers: upper-half corruption is outside the mask
        start_run(0, 1'b0, 3'd3);
        check_val("bytes_latched", {61'd0, obytes[0]}, 64'd3);
        serve(0, BASE,         1'b1, 64'd0, -1, 1'b0);
        serve(0, BASE,         1'b0, 64'hFFFF_FFFF_0000_0000, -1, 1'b0);
        serve(0, BASE + 64'd8, 1'b1, 64'd0, -1, 1'b0);
        serve(0, BASE + 64'd8, 1'b0, 64'hFFFF_FFFF_0000_0000, -1, 1'b0);
        wait_done(0, 32'd2, 32'd0);

        // 4-byte transfers: low-byte corruption is an error
        start_run(0, 1'b0, 3'd3);
        serve(0, BASE,         1'b1, 64'd0, -1, 1'b0);
        serve(0, BASE,         1'b0, 64'h0000_0000_0000_00FF, -1, 1'b0);
        serve(0, BASE + 64'd8, 1'b1, 64'd0, -1, 1'b0);
        serve(0, BASE + 64'd8, 1'b0, 64'd0, -1, 1'b0);
        wait_done(0, 32'd1, 32'd1);
        check_val("ferr_b3", ferr[0], BASE);

        // 4-word window, 6 pairs, no gap: 0,8,10,18,0,8
        start_run(1, 1'b0, 3'd7);
        for (int i = 0; i < 6; i++) begin
            serve(1, BASE + 64'((i % 4) * 8), 1'b1, 64'd0, 0, 1'b0);
            serve(1, BASE + 64'((i % 4) * 8), 1'b0, 64'd0, 0, 1'b0);
        end
        wait_done(1, 32'd6, 32'd0);

        // LFSR addressing: ACE1 -> 59C3 -> B387, low 9 bits times 8
        rnd_addr[0] = 64'h8000_0708;
        rnd_addr[1] = 64'h8000_0E18;
        rnd_addr[2] = 64'h8000_0C38;
        start_run(2, 1'b1, 3'd7);
        for (int i = 0; i < 3; i++) begin
            serve(2, rnd_addr[i], 1'b1, 64'd0, 1, 1'b0);
            serve(2, rnd_addr[i], 1'b0, 64'd0, 1, 1'b0);
        end
        wait_done(2, 32'd3, 32'd0);
        // Ack without a request must not count anything
        ack[2] = 1'b1;
        rdata[2] = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (10) @(negedge clk);
        ack[2] = 1'b0;
        check_val("ack_idle_pass", {32'd0, pass[2]}, 64'd3);
        check_val("ack_idle_err", {32'd0, err[2]}, 64'd0);
        check_val("ack_idle_req", {63'd0, req[2]}, 64'd0);

        // Endless run stopped during the write request
        start_run(3, 1'b0, 3'd7);
        serve(3, BASE, 1'b1, 64'd0, 2, 1'b1);
        serve(3, BASE, 1'b0, 64'd0, 2, 1'b0);
        wait_done(3, 32'd1, 32'd0);
        seen_req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req[3] === 1'b1) seen_req++;
        end
        check_val("no_req_after_stop", 64'(seen_req), 64'd0);

        // Stop while idle is ignored; reset mid-request
        stop[3] = 1'b1;
        @(negedge clk);
        stop[3] = 1'b0;
        start_run(3, 1'b0, 3'd7);
        serve(3, BASE, 1'b1, 64'd0, 2, 1'b0);
        serve(3, BASE, 1'b0, 64'd0, 2, 1'b0);
        seen_req = 0;
        while (req[3] !== 1'b1 && seen_req < 50) begin
            @(negedge clk);
            seen_req++;
        end
        check_val("second_pair_req", {63'd0, req[3]}, 64'd1);
        check_val("second_pair_addr", addr[3], BASE + 64'd8);
        check_val("pass_before_rst", {32'd0, pass[3]}, 64'd1);
        rst[3] = 1'b1;
        @(negedge clk);
        rst[3] = 1'b0;
        check_val("rst_mid_req", {63'd0, req[3]}, 64'd0);
        check_val("rst_mid_addr", addr[3], BASE);
        check_val("rst_mid_pass", {32'd0, pass[3]}, 64'd0);
        check_val("rst_mid_busy", {63'd0, busy[3]}, 64'd0);
        @(negedge clk);
        check_val("rst_mid_req2", {63'd0, req[3]}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cache_traffic_gen.md
Name: cache_traffic_gen

Overview:
Parametrised traffic generator and self-checker for the cache request interface, i.e. the addr/wdata/bytes/op/req/rdata/ack port of cache_top.
- For each address it issues a write, then a read-back of the same address, and compares the returned data.
- Supports sequential or LFSR-random addressing over a power-of-two window, a programmable inter-request gap, a finite or endless run length, and error/pass accounting.
- Sits in front of cache_top in cache bring-up testbenches and SoC self-test builds.

Parameters:
ADDR_BASE, 64'h8000_0000, first byte address of the test window (8-byte aligned).
ADDR_WORDS, 512, number of 8-byte words in the window; power of two, at least 2.
GAP_CYCLES, 5, idle cycles with o_cache_req low before each request; 0 is allowed.
ITERATIONS, 0, number of write/read pairs per run; 0 means run until i_stop.
DATA_TAG, 32'h0123_4567, constant placed in wdata[63:32].
LFSR_SEED, 16'hACE1, reset/start value of the random-address LFSR; must be nonzero.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle start pulse; honoured only when idle
i_stop  in  1  request stop after the current pair completes
i_mode  in  1  0 = sequential, 1 = LFSR random; latched at start
i_bytes  in  3  transfer size minus 1 (7 = 8 bytes); latched at start
o_cache_addr  out  64  request address
o_cache_wdata  out  64  write data
o_cache_bytes  out  3  size field
o_cache_op  out  1  0 = read (REQ_READ), 1 = write (REQ_WRITE)
o_cache_req  out  1  request valid
i_cache_rdata  in  64  read data, valid in the read handshake cycle
i_cache_ack  in  1  request accepted/complete
o_busy  out  1  run in progress
o_done  out  1  run finished; held until next start
o_pass_cnt  out  32  matched reads, saturating
o_err_cnt  out  32  mismatched reads, saturating
o_first_err_addr  out  64  address of the first mismatch in the run

Behaviour:
- Reset values:
  - req = 0, op = 0, bytes = 7, addr = ADDR_BASE.
  - wdata = {DATA_TAG, ADDR_BASE[31:0]}.
  - busy = 0, done = 0, counters = 0, first_err_addr = 0.
  - LFSR = LFSR_SEED; state IDLE.
- Handshake:
  - hs = o_cache_req & i_cache_ack.
  - i_cache_ack while req is low is ignored.
  - addr, wdata, op and bytes stay stable from req rise through the hs cycle.
  - req deasserts on the edge after hs.
- States:
  - IDLE:
    - On i_start, latch mode/bytes; clear counters, done and first_err_addr; reload LFSR = LFSR_SEED.
    - Load addr = first address: ADDR_BASE when sequential, ADDR_BASE + LFSR[log2(ADDR_WORDS)-1:0]*8 when random.
    - Set op = write and busy = 1, then go to GAP.
  - GAP:
    - Counter clears on entry.
    - req rises GAP_CYCLES edges after entry.
    - With GAP_CYCLES = 0, req rises on the entry edge, so there is no idle cycle.
    - Then go to REQ.
  - REQ:
    - Wait for hs.
    - Write hs: op <= read, same addr, go to GAP.
    - Read hs: compare, count, advance the address, op <= write, then go to GAP, or to DONE if the stop condition holds.
  - DONE: busy = 0, done = 1; return to IDLE (done stays high until next i_start).
- Data pattern: wdata = {DATA_TAG, addr[31:0]}, recomputed whenever addr changes.
- Compare: match iff (i_cache_rdata ^ o_cache_wdata) & mask == 0, where mask = low (bytes+1)*8 bits.
- Counting:
  - Match increments pass_cnt; mismatch increments err_cnt.
  - first_err_addr is captured only when err_cnt was 0.
  - Both counters saturate at 32'hFFFF_FFFF.
- Address advance:
  - Sequential: addr + 8; after word ADDR_WORDS-1 it wraps to ADDR_BASE.
  - Random: LFSR steps once per read hs (x^16+x^14+x^13+x^11+1, Fibonacci, shifts left), and addr = ADDR_BASE + LFSR[log2(ADDR_WORDS)-1:0]*8.
- Stop condition, evaluated at read hs:
  - i_stop seen high at any cycle since the last read hs (sticky flag), or
  - ITERATIONS != 0 and the completed pair count equals ITERATIONS.
  - i_stop in IDLE/DONE is ignored, and the flag clears on start.
- i_start while busy is ignored. An outstanding request is never abandoned, except by rst.
- rst mid-run: all state returns to reset values at that edge, and req is low the following cycle.

Test Plan:
- Reset, then i_start with mode 0, bytes 7, GAP_CYCLES 5, ITERATIONS 2, and a memory model acking 1 cycle after req:
  - Expect W 0x8000_0000 data 0x01234567_8000_0000, R 0x8000_0000, W 0x8000_0008, R 0x8000_0008.
  - pass_cnt = 2, done = 1, busy = 0.
  - req low for exactly 5 cycles between requests.
- Model corrupts rdata bit 40 on the read of 0x8000_0008:
  - err_cnt = 1, pass_cnt = 1, first_err_addr = 0x8000_0008.
  - A second corruption later leaves first_err_addr unchanged.
- bytes = 3 with rdata[63:32] corrupted → counted as a pass; corrupt rdata[7:0] → counted as an error.
- ADDR_WORDS 4, ITERATIONS 6, sequential → address order ...0,8,10,18,0,8 (wrap); GAP_CYCLES 0 → req rises on the edge after the previous hs, with no idle cycle.
- Mode 1, ITERATIONS 3 → addresses match a reference LFSR from 0xACE1, all within the window; ack held high constantly with no req → no counter changes.
- ITERATIONS 0: pulse i_stop during a write request → run finishes after the following read hs. Assert rst mid-request → req = 0, addr = ADDR_BASE, counters 0 the next cycle.
